// File: rtl/line_score_engine.sv
// line_score_engine: walks the Bresenham line between two pins, reads every
// pixel from an external image RAM and returns sum(2*pix - PIX_MAX) plus the
// pixel count. In commit mode each pixel is written back brightened by a
// saturating WEIGHT, recording the placed string in the residual image.
module line_score_engine #(
  parameter int COORD_W = 9,
  parameter int PIX_W   = 8,
  parameter int RD_LAT  = 2,
  parameter int WEIGHT  = 64,
  parameter int ACC_W   = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic [COORD_W-1:0]   req_x0,
  input  logic [COORD_W-1:0]   req_y0,
  input  logic [COORD_W-1:0]   req_x1,
  input  logic [COORD_W-1:0]   req_y1,
  input  logic                 req_commit,
  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic [ACC_W-1:0]     resp_score,
  output logic [COORD_W:0]     resp_count,
  output logic                 mem_rd_en,
  output logic [2*COORD_W-1:0] mem_raddr,
  input  logic [PIX_W-1:0]     mem_rdata,
  output logic                 mem_we,
  output logic [2*COORD_W-1:0] mem_waddr,
  output logic [PIX_W-1:0]     mem_wdata
);

  localparam int AW = 2 * COORD_W;
  localparam int EW = COORD_W + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WALK  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [PIX_W-1:0] PIX_MAX_V = {PIX_W{1'b1}};
  localparam logic [ACC_W-1:0] PIX_MAX_A = {{(ACC_W-PIX_W){1'b0}}, PIX_MAX_V};

  logic [1:0]                 state_q, state_d;
  logic [COORD_W-1:0]         x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0]         x1_q, x1_d, y1_q, y1_d;
  logic [COORD_W-1:0]         dx_q, dx_d, dy_q, dy_d;
  logic                       sy_neg_q, sy_neg_d;
  logic signed [EW-1:0]       err_q, err_d;
  logic                       commit_q, commit_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [COORD_W:0]           count_q, count_d;
  logic [RD_LAT-1:0]          vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0][AW-1:0]  addr_pipe_q, addr_pipe_d;

  // Canonicalised request endpoints
  logic                       swap;
  logic [COORD_W-1:0]         ax, ay, bx, by, c_dx, c_dy;
  logic                       c_sy_neg;

  // Walk step terms
  logic signed [EW:0]         e2, dx_w, dy_w;
  logic signed [EW-1:0]       dx_e, dy_e, err_n;
  logic                       step_x, step_y, at_end;

  // Read-return datapath
  logic                       ret_vld;
  logic [ACC_W-1:0]           pix_term;
  logic [31:0]                sat_sum;
  logic [PIX_W-1:0]           wdata_sat;

  // Order endpoints so x always increases; only y needs a direction bit.
  always_comb begin
    swap     = (req_x0 > req_x1) || ((req_x0 == req_x1) && (req_y0 > req_y1));
    ax       = swap ? req_x1 : req_x0;
    ay       = swap ? req_y1 : req_y0;
    bx       = swap ? req_x0 : req_x1;
    by       = swap ? req_y0 : req_y1;
    c_dx     = bx - ax;
    c_sy_neg = by < ay;
    c_dy     = c_sy_neg ? (ay - by) : (by - ay);
  end

  // One Bresenham step from the current error term; x and y may both move.
  always_comb begin
    e2     = {err_q, 1'b0};
    dx_w   = $signed({3'b000, dx_q});
    dy_w   = $signed({3'b000, dy_q});
    dx_e   = $signed({2'b00, dx_q});
    dy_e   = $signed({2'b00, dy_q});
    step_x = e2 > -dy_w;
    step_y = e2 < dx_w;
    err_n  = err_q;
    if (step_x) err_n = err_n - dy_e;
    if (step_y) err_n = err_n + dx_e;
    at_end = (x_q == x1_q) && (y_q == y1_q);
  end

  // Score contribution and saturated write-back of the returning pixel.
  always_comb begin
    ret_vld   = vld_pipe_q[RD_LAT-1];
    pix_term  = {{(ACC_W-PIX_W-1){1'b0}}, mem_rdata, 1'b0} - PIX_MAX_A;
    sat_sum   = 32'(mem_rdata) + 32'(WEIGHT);
    wdata_sat = (sat_sum > 32'(PIX_MAX_V)) ? PIX_MAX_V : sat_sum[PIX_W-1:0];
  end

  // Next-state: FSM, walk registers, read-tracking pipeline, accumulator.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    sy_neg_d    = sy_neg_q;
    err_d       = err_q;
    commit_d    = commit_q;
    acc_d       = acc_q;
    count_d     = count_q;

    vld_pipe_d     = '0;
    addr_pipe_d    = '0;
    vld_pipe_d[0]  = mem_rd_en;
    addr_pipe_d[0] = mem_raddr;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      addr_pipe_d[i] = addr_pipe_q[i-1];
    end

    if (ret_vld) acc_d = acc_q + pix_term;

    case (state_q)
      S_IDLE: begin
        if (req_val) begin
          x_d      = ax;
          y_d      = ay;
          x1_d     = bx;
          y1_d     = by;
          dx_d     = c_dx;
          dy_d     = c_dy;
          sy_neg_d = c_sy_neg;
          err_d    = $signed({2'b00, c_dx}) - $signed({2'b00, c_dy});
          commit_d = req_commit;
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_WALK;
        end
      end
      S_WALK: begin
        count_d = count_q + 1'b1;
        if (at_end) begin
          state_d = S_DRAIN;
        end else begin
          err_d = err_n;
          if (step_x) x_d = x_q + 1'b1;
          if (step_y) y_d = sy_neg_q ? (y_q - 1'b1) : (y_q + 1'b1);
        end
      end
      S_DRAIN: begin
        // The final read is returning this cycle when nothing else is in flight.
        if (vld_pipe_d == '0) state_d = S_RESP;
      end
      default: begin
        if (resp_rdy) state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset also drops in-flight reads so no write follows it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      sy_neg_q    <= 1'b0;
      err_q       <= '0;
      commit_q    <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
      vld_pipe_q  <= '0;
      addr_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      sy_neg_q    <= sy_neg_d;
      err_q       <= err_d;
      commit_q    <= commit_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      vld_pipe_q  <= vld_pipe_d;
      addr_pipe_q <= addr_pipe_d;
    end
  end

  assign req_rdy    = (state_q == S_IDLE);
  assign resp_val   = (state_q == S_RESP);
  assign resp_score = acc_q;
  assign resp_count = count_q;
  assign mem_rd_en  = (state_q == S_WALK);
  assign mem_raddr  = mem_rd_en ? {y_q, x_q} : '0;
  assign mem_we     = ret_vld & commit_q;
  assign mem_waddr  = mem_we ? addr_pipe_q[RD_LAT-1] : '0;
  assign mem_wdata  = mem_we ? wdata_sat : '0;

endmodule

// File: tb/tb_line_score_engine.sv
// Scoreboard bench for line_score_engine: driver pushes expected reads,
// writes and responses; a negedge monitor pops and compares them.
module tb_line_score_engine;
  localparam int COORD_W = 9;
  localparam int PIX_W   = 8;
  localparam int RD_LAT  = 2;
  localparam int WEIGHT  = 64;
  localparam int ACC_W   = 20;
  localparam int AW      = 2 * COORD_W;
  localparam int PIX_MAX = (1 << PIX_W) - 1;
  localparam int DIM     = 1 << COORD_W;

  typedef struct { int addr; int data; int orig; } wr_t;
  typedef struct { int score; int count; int t_acc; } exp_t;
  typedef struct { int addr; int data; } poke_t;

  logic clk = 1'b0;
  logic reset;
  logic req_val, req_rdy, req_commit;
  logic [COORD_W-1:0] req_x0, req_y0, req_x1, req_y1;
  logic resp_val, resp_rdy;
  logic [ACC_W-1:0] resp_score;
  logic [COORD_W:0] resp_count;
  logic mem_rd_en, mem_we;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [PIX_W-1:0] mem_rdata, mem_wdata;

  logic rdy_man = 1'b1, rnd_rdy = 1'b1, rnd_bp = 1'b0;
  assign resp_rdy = rnd_bp ? rnd_rdy : rdy_man;

  int checks = 0, errors = 0;
  int cyc = 0;
  bit mon_on = 0;
  bit resp_seen = 0;
  int last_score, last_count, last_tacc;
  int last_exp_score, last_exp_count;

  int    rdq[$];
  wr_t   wrq[$];
  exp_t  expq[$];
  poke_t pokeq[$];

  logic [PIX_W-1:0] img     [0:(1<<AW)-1];
  logic [PIX_W-1:0] ref_img [0:(1<<AW)-1];
  logic [AW-1:0]    rp      [RD_LAT];

  line_score_engine #(.COORD_W(COORD_W), .PIX_W(PIX_W), .RD_LAT(RD_LAT),
                      .WEIGHT(WEIGHT), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .req_commit(req_commit), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_score(resp_score), .resp_count(resp_count),
    .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Image RAM: fixed read latency, write port, plus bench pokes.
  always @(posedge clk) begin
    poke_t p;
    while (pokeq.size() > 0) begin
      p = pokeq.pop_front();
      img[p.addr] <= PIX_W'(p.data);
    end
    if (mem_we) img[mem_waddr] <= mem_wdata;
    rp[0] <= mem_raddr;
    for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
  end
  assign mem_rdata = img[rp[RD_LAT-1]];

  // Random response backpressure
  always @(posedge clk) begin
    #1 rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_pix(input int x, input int y, input int v);
    poke_t p;
    p.addr = y * DIM + x;
    p.data = v;
    ref_img[p.addr] = PIX_W'(v);
    pokeq.push_back(p);
  endtask

  // Reference: enumerate line pixels, score from the reference image and
  // queue the expected reads and commit writes.
  task automatic model_line(input int x0, input int y0, input int x1, input int y1,
                            input bit commit, output int score);
    int ax, ay, bx, by, dx, dy, sy, err, e2, x, y, a, p, w;
    wr_t wr;
    if (x0 > x1 || (x0 == x1 && y0 > y1)) begin
      ax = x1; ay = y1; bx = x0; by = y0;
    end else begin
      ax = x0; ay = y0; bx = x1; by = y1;
    end
    dx = bx - ax;
    dy = (by >= ay) ? by - ay : ay - by;
    sy = (by >= ay) ? 1 : -1;
    err = dx - dy;
    x = ax; y = ay; score = 0;
    for (int k = 0; k < 4 * DIM; k++) begin
      a = y * DIM + x;
      rdq.push_back(a);
      p = int'(ref_img[a]);
      score += 2 * p - PIX_MAX;
      if (commit) begin
        w = (p + WEIGHT > PIX_MAX) ? PIX_MAX : p + WEIGHT;
        wr.addr = a; wr.data = w; wr.orig = p;
        wrq.push_back(wr);
        ref_img[a] = PIX_W'(w);
      end
      if (x == bx && y == by) break;
      e2 = 2 * err;
      if (e2 > -dy) begin err -= dy; x += 1; end
      if (e2 < dx)  begin err += dx; y += sy; end
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (expq.size() != 0 && g < 20000) begin
      @(posedge clk); #1; g++;
    end
    if (expq.size() != 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no response expected one within 20000 cycles");
      expq.delete(); rdq.delete(); wrq.delete();
    end
  endtask

  task automatic issue(input int x0, input int y0, input int x1, input int y1,
                       input bit commit, input bit push_exp);
    int sc, dxa, dya, g;
    exp_t e;
    model_line(x0, y0, x1, y1, commit, sc);
    dxa = (x1 > x0) ? x1 - x0 : x0 - x1;
    dya = (y1 > y0) ? y1 - y0 : y0 - y1;
    last_exp_score = sc;
    last_exp_count = ((dxa > dya) ? dxa : dya) + 1;
    req_x0 = COORD_W'(x0); req_y0 = COORD_W'(y0);
    req_x1 = COORD_W'(x1); req_y1 = COORD_W'(y1);
    req_commit = commit;
    req_val = 1'b1;
    g = 0;
    @(negedge clk);
    while (!req_rdy && g < 5000) begin @(negedge clk); g++; end
    if (!req_rdy) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got req_rdy 0 expected 1");
    end
    e.score = sc; e.count = last_exp_count; e.t_acc = cyc;
    last_tacc = cyc;
    if (push_exp) expq.push_back(e);
    @(posedge clk); #1;
    req_val = 1'b0;
    req_x0 = COORD_W'($urandom); req_y0 = COORD_W'($urandom);
    req_x1 = COORD_W'($urandom); req_y1 = COORD_W'($urandom);
    req_commit = 1'($urandom);
  endtask

  task automatic do_line(input int x0, input int y0, input int x1, input int y1,
                         input bit commit);
    wait_idle();
    issue(x0, y0, x1, y1, commit, 1'b1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " req_rdy"},    int'(req_rdy), 1);
    chk({tag, " resp_val"},   int'(resp_val), 0);
    chk({tag, " mem_rd_en"},  int'(mem_rd_en), 0);
    chk({tag, " mem_we"},     int'(mem_we), 0);
    chk({tag, " resp_score"}, int'(resp_score), 0);
    chk({tag, " resp_count"}, int'(resp_count), 0);
    chk({tag, " raddr"},      int'(mem_raddr), 0);
    chk({tag, " waddr"},      int'(mem_waddr), 0);
    chk({tag, " wdata"},      int'(mem_wdata), 0);
  endtask

  // Monitor: consumes expected reads, writes and responses.
  always @(negedge clk) begin
    int a;
    wr_t w;
    exp_t e;
    if (mon_on) begin
      if (mem_rd_en) begin
        if (rdq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got read of %0d expected no read", mem_raddr);
        end else begin
          a = rdq.pop_front();
          chk("rd_addr", int'(mem_raddr), a);
        end
      end
      if (mem_we) begin
        if (wrq.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: got write of %0d expected no write", mem_waddr);
        end else begin
          w = wrq.pop_front();
          chk("wr_addr", int'(mem_waddr), w.addr);
          chk("wr_data", int'(mem_wdata), w.data);
        end
      end
      if (resp_val && !resp_seen) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: got resp_val 1 expected 0");
        end else begin
          e = expq.pop_front();
          last_score = int'($signed(resp_score));
          last_count = int'(resp_count);
          chk("resp_score", last_score, e.score);
          chk("resp_count", last_count, e.count);
          chk("resp_latency", cyc - e.t_acc, e.count + RD_LAT + 1);
        end
      end
      resp_seen = resp_val && !resp_rdy;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s1, t1, g, diffs;
    poke_t p;
    reset = 1'b0; req_val = 1'b0; req_commit = 1'b0;
    req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      p.addr = i;
      p.data = int'($urandom_range(0, PIX_MAX));
      ref_img[i] = PIX_W'(p.data);
      pokeq.push_back(p);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1; mon_on = 1;
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;

    // Horizontal line, all 255, score only
    for (int x = 0; x < 4; x++) set_pix(x, 0, 255);
    do_line(0, 0, 3, 0, 0);
    wait_idle();
    chk("horiz score", last_score, 1020);
    chk("horiz count", last_count, 4);

    // Degenerate single pixel
    set_pix(5, 5, 0);
    do_line(5, 5, 5, 5, 0);
    wait_idle();
    chk("point score", last_score, -255);
    chk("point count", last_count, 1);

    // Steep line and its swapped request
    do_line(0, 0, 1, 3, 0);
    wait_idle();
    s1 = last_score;
    do_line(1, 3, 0, 0, 0);
    wait_idle();
    chk("swap score", last_score, s1);

    // Commit then re-score
    set_pix(10, 10, 200); set_pix(11, 9, 200); set_pix(12, 8, 200);
    do_line(10, 10, 12, 8, 1);
    wait_idle();
    chk("commit score", last_score, 435);
    do_line(10, 10, 12, 8, 0);
    wait_idle();
    chk("rescore", last_score, 765);

    // Back-to-back throughput: N=8
    do_line(20, 30, 27, 33, 0);
    t1 = last_tacc;
    do_line(27, 33, 20, 30, 0);
    chk("throughput", last_tacc - t1, 8 + RD_LAT + 2);

    // Response backpressure
    wait_idle();
    rdy_man = 1'b0;
    do_line(40, 40, 45, 47, 1);
    g = 0;
    @(negedge clk);
    while (!resp_val && g < 1000) begin @(negedge clk); g++; end
    repeat (5) begin
      @(negedge clk);
      chk("bp resp_val", int'(resp_val), 1);
      chk("bp score", int'($signed(resp_score)), last_exp_score);
      chk("bp count", int'(resp_count), last_exp_count);
      chk("bp req_rdy", int'(req_rdy), 0);
      chk("bp rd_en", int'(mem_rd_en), 0);
      chk("bp we", int'(mem_we), 0);
    end
    @(posedge clk); #1 rdy_man = 1'b1;
    @(negedge clk);
    chk("bp handshake", int'(resp_val), 1);
    @(negedge clk);
    chk("bp after req_rdy", int'(req_rdy), 1);
    chk("bp after resp_val", int'(resp_val), 0);
    @(posedge clk); #1;

    // Reset in the middle of a 100-pixel commit walk
    wait_idle();
    issue(0, 100, 99, 150, 1'b1, 1'b0);
    repeat (40) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    while (wrq.size() > 0) begin
      wr_t w;
      w = wrq.pop_back();
      ref_img[w.addr] = PIX_W'(w.orig);
    end
    rdq.delete(); expq.delete();
    @(negedge clk);
    check_reset("midreset");
    @(posedge clk); #1;
    do_line(5, 300, 300, 20, 1);
    wait_idle();

    // Random lines with random response backpressure
    rnd_bp = 1'b1;
    repeat (30) begin
      do_line(int'($urandom_range(0, DIM-1)), int'($urandom_range(0, DIM-1)),
              int'($urandom_range(0, DIM-1)), int'($urandom_range(0, DIM-1)),
              1'($urandom));
    end
    wait_idle();
    rnd_bp = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    diffs = 0;
    for (int i = 0; i < (1 << AW); i++)
      if (img[i] !== ref_img[i]) diffs++;
    chk("image diffs", diffs, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_score_engine.md
# line_score_engine

Parametrised all-octant Bresenham line engine for the string-art solver. It walks the pixel line between two pin coordinates and reads each pixel from an external dual-port image RAM. It returns a signed score, sum of (2·pixel − PIX_MAX), together with the pixel count. In commit mode it also writes back each pixel brightened by a saturating weight, which records the string as placed in the residual image.

## Interface
- COORD_W, 9: bits per x/y coordinate; image is 2^COORD_W × 2^COORD_W.
- PIX_W, 8: pixel width; PIX_MAX = 2^PIX_W − 1.
- RD_LAT, 2: RAM read latency in cycles (≥1).
- WEIGHT, 64: commit-mode saturating increment.
- ACC_W, 20: score width; must be ≥ COORD_W+PIX_W+3.
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- req_val / req_rdy  in / out  1  request handshake
- req_x0, req_y0, req_x1, req_y1  in  COORD_W  endpoints
- req_commit  in  1  0 = score only, 1 = score and write back
- resp_val / resp_rdy  out / in  1  response handshake
- resp_score  out  ACC_W signed  accumulated score
- resp_count  out  COORD_W+1  pixels visited
- mem_rd_en  out  1; mem_raddr  out  2·COORD_W  {y,x}
- mem_rdata  in  PIX_W  valid RD_LAT cycles after mem_rd_en
- mem_we  out  1; mem_waddr  out  2·COORD_W; mem_wdata  out  PIX_W

## Operation
- States are IDLE, WALK, DRAIN and RESP.
- **IDLE**
  - req_rdy=1.
  - On req_val the request is latched and the endpoints are canonicalised: swap if x0>x1, or if x0==x1 and y0>y1. Scores are therefore independent of endpoint order.
  - Latch dx=|x1−x0|, dy=|y1−y0|, sx=±1, sy=±1, err=dx−dy (signed COORD_W+2). Clear the accumulator and count. Go to WALK.
- **WALK**
  - Each cycle, assert mem_rd_en with the current {y,x} and increment count.
  - If (x,y)==(x1,y1), go to DRAIN.
  - Otherwise compute e2=2·err. If e2>−dy then err−=dy, x+=sx. If e2<dx then err+=dx, y+=sy. Both may fire in one cycle.
  - Endpoints are inclusive. N = max(dx,dy)+1 pixels.
- **Read pipeline**
  - An RD_LAT-deep valid/address shift register tracks outstanding reads.
  - When a returning read is valid: acc += 2·rdata − PIX_MAX, sign-extended to ACC_W.
  - If commit is set, in the same cycle assert mem_we with waddr = the read address and wdata = min(rdata+WEIGHT, PIX_MAX).
  - A Bresenham line never revisits a pixel, so there is no read-after-write hazard within one line.
- **DRAIN**: wait until the pipeline is empty, then go to RESP.
- **RESP**
  - resp_val=1; resp_score and resp_count are held stable.
  - On resp_val&&resp_rdy, go to IDLE.
- Degenerate line (x0,y0)==(x1,y1): one pixel, N=1.
- reset=0 at any state:
  - Go to IDLE and clear the pipeline valids.
  - Pending writes are dropped (no mem_we after reset).
  - All outputs are at reset values.

## Timing
- Reset values:
  - req_rdy=1 in the first cycle after reset release.
  - resp_val, mem_rd_en and mem_we = 0.
  - resp_score, resp_count, addresses and wdata = 0.
- Request accepted at cycle T (req_val&&req_rdy):
  - Reads are issued in cycles T+1 … T+N, one per cycle with no bubbles.
  - The last data returns at T+N+RD_LAT.
  - resp_val rises at T+N+RD_LAT+1.
- Commit writes occur in cycles T+1+RD_LAT … T+N+RD_LAT.
- req_rdy=0 from T+1 until the cycle after the response handshake. Back-to-back throughput is one line per N+RD_LAT+2 cycles.
- resp_rdy may be held low indefinitely. Outputs stay stable and no memory traffic occurs.
- req_* are sampled only in the acceptance cycle. Changes afterwards have no effect.

## Test plan
- Horizontal line (0,0)→(3,0), all pixels 255, score mode, RD_LAT=2:
  - Reads at {0,0}…{0,3}.
  - resp at T+7: score=1020, count=4.
  - No mem_we.
- Single point (5,5)→(5,5), pixel 0:
  - One read; resp at T+4.
  - score=−255, count=1.
- Steep line (0,0)→(1,3):
  - Read order is (0,0),(0,1),(1,2),(1,3).
  - The swapped request (1,3)→(0,0) gives an identical address sequence and score.
- Commit of (10,10)→(12,8), pixels 200, WEIGHT=64:
  - Writes 255 to (10,10),(11,9),(12,8); score=3·145=435.
  - A repeat score-only request returns 765.
- Backpressure: resp_rdy low 5 cycles after resp_val.
  - resp_val, score and count stay stable.
  - req_rdy=0 and no mem_rd_en.
  - Handshake, then req_rdy=1 the next cycle.
- Reset asserted mid-WALK of a 100-pixel commit line:
  - Next cycle: IDLE, req_rdy=1, mem_we=0, resp_val=0.
  - A fresh request then completes correctly.
